// File: rtl/rf_wb_arbiter.sv
// Register-file write-port scheduler: two small writeback FIFOs (ALU, LSU) round-robined onto
// one registered write port, with a pending-write bitmap for the hazard logic.
module rf_wb_arbiter #(
  parameter int N     = 32,
  parameter int ADDR  = 5,
  parameter int DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [ADDR-1:0]      alu_addr_i,
  input  logic [N-1:0]         alu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [ADDR-1:0]      lsu_addr_i,
  input  logic [N-1:0]         lsu_data_i,
  output logic                 rd_wr_o,
  output logic [ADDR-1:0]      rd_addr_o,
  output logic [N-1:0]         rd_data_o,
  output logic [2**ADDR-1:0]   pend_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  // Index 0 is the ALU source, index 1 the LSU source.
  logic [ADDR-1:0] fifo_addr [2][DEPTH];
  logic [N-1:0]    fifo_data [2][DEPTH];
  logic [PW-1:0]   wr_ptr    [2];
  logic [PW-1:0]   rd_ptr    [2];
  logic [CW-1:0]   count     [2];

  logic            in_valid  [2];
  logic [ADDR-1:0] in_addr   [2];
  logic [N-1:0]    in_data   [2];
  logic            ready     [2];
  logic            nonempty  [2];
  logic            push      [2];
  logic            pop       [2];

  src_e            rr;
  logic            grant;
  src_e            grant_src;
  logic            sel;
  logic [PW-1:0]   off;
  logic [2**ADDR-1:0] pend;

  assign in_valid[0] = alu_valid_i;
  assign in_addr[0]  = alu_addr_i;
  assign in_data[0]  = alu_data_i;
  assign in_valid[1] = lsu_valid_i;
  assign in_addr[1]  = lsu_addr_i;
  assign in_data[1]  = lsu_data_i;

  assign alu_ready_o = ready[0];
  assign lsu_ready_o = ready[1];

  // NOTE: every combinational output gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_ALU;
    for (int s = 0; s < 2; s++) begin
      ready[s]    = count[s] < CW'(DEPTH);
      nonempty[s] = count[s] != '0;
      // Writes to x0 complete the handshake but are dropped here.
      push[s]     = in_valid[s] && ready[s] && (in_addr[s] != '0);
    end
    grant = nonempty[0] || nonempty[1];
    if (nonempty[0] && nonempty[1]) grant_src = rr;
    else if (nonempty[1])           grant_src = SRC_LSU;
    else                            grant_src = SRC_ALU;
    pop[0] = grant && (grant_src == SRC_ALU);
    pop[1] = grant && (grant_src == SRC_LSU);
  end

  assign sel = (grant_src == SRC_LSU);

  // NOTE: FIFO storage is not reset; the reset pointers and counts make stale entries invisible.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        fifo_addr[s][wr_ptr[s]] <= in_addr[s];
        fifo_data[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      rr        <= SRC_ALU;
      rd_wr_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: count[s] <= count[s];
        endcase
      end
      rd_wr_o <= grant;
      if (grant) begin
        rd_addr_o <= fifo_addr[sel][rd_ptr[sel]];
        rd_data_o <= fifo_data[sel][rd_ptr[sel]];
        rr        <= (grant_src == SRC_ALU) ? SRC_LSU : SRC_ALU;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        off = PW'(e) - rd_ptr[s];
        if ({1'b0, off} < count[s]) pend[fifo_addr[s][e]] = 1'b1;
      end
    end
    if (rd_wr_o) pend[rd_addr_o] = 1'b1;
    pend[0] = 1'b0;
  end

  assign pend_o = pend;

endmodule
